channel_serializer: RTL and testbench
=====================================

# channel_serializer

Converts one multi-channel word (NUM_CHANNEL lanes of BIT_WIDTH bits) into a stream of single-channel beats, one channel per cycle. It is the receiving end of the multi-channel layer interface that `channel_buffer` drives. It sits between a channel buffer and a per-channel processing stage that consumes one channel at a time. Valid/ready handshakes are used on both sides.

## Interface
- BIT_WIDTH, 8, bit width of one channel
- NUM_CHANNEL, 3, channels per input word (>= 1); CIDX_W = max(1, clog2(NUM_CHANNEL))
- clk  input  1  system clock
- rst  input  1  system reset: synchronous, active-high, sampled on the rising edge of clk
- prev_layer_valid  input  1  input word valid
- prev_layer_rdy  output  1  input word ready
- prev_layer_data  input  NUM_CHANNEL*BIT_WIDTH  input word; channel k = bits [k*BIT_WIDTH +: BIT_WIDTH]
- next_layer_rdy  input  1  downstream ready
- next_layer_valid  output  1  output beat valid
- next_layer_data  output  BIT_WIDTH  current channel value
- next_layer_chan  output  CIDX_W  index of the current channel (0..NUM_CHANNEL-1)
- next_layer_last  output  1  high on the beat carrying channel NUM_CHANNEL-1

## Operation
- Handshake on either side:
  - A transfer occurs on a rising edge where valid && rdy.
  - Once next_layer_valid is asserted, next_layer_data, next_layer_chan and next_layer_last hold stable until the transfer.
- Storage:
  - One word holding register (hold_reg, NUM_CHANNEL*BIT_WIDTH).
  - Channel counter chan_cnt (CIDX_W).
  - No FIFO and no input bypass: all outputs are registered or decoded from registers.
- State machine with 2 states, IDLE and SEND:
  - IDLE:
    - prev_layer_rdy = 1.
    - On an input transfer: hold_reg <= prev_layer_data, chan_cnt <= 0, go to SEND.
  - SEND:
    - next_layer_valid = 1.
    - next_layer_data = hold_reg channel chan_cnt.
    - next_layer_chan = chan_cnt.
    - next_layer_last = (chan_cnt == NUM_CHANNEL-1).
    - Output transfer on a non-last beat: chan_cnt += 1, stay in SEND.
    - Output transfer on the last beat with no simultaneous input transfer: go to IDLE.
    - Output transfer on the last beat with a simultaneous input transfer: load the new word, chan_cnt <= 0, stay in SEND (no bubble).
- prev_layer_rdy = !rst && (state == IDLE || (state == SEND && next_layer_last && next_layer_rdy)).
  - This is combinational from next_layer_rdy; the downstream path must not loop back through it.
- Channel order is ascending: channel 0 first, NUM_CHANNEL-1 last.
- The counter never wraps beyond NUM_CHANNEL-1 (non-power-of-2 NUM_CHANNEL included).
- NUM_CHANNEL == 1:
  - Every beat is last; chan = 0.
  - Behaves as a single-register pipeline stage with full throughput.
- next_layer_rdy low in SEND: state, counter and outputs hold indefinitely.
- prev_layer_valid deasserting while in SEND has no effect; the held word is completed.
- Reset:
  - Any state goes to IDLE on the edge where rst = 1.
  - chan_cnt = 0, hold_reg = 0, and the in-flight word is discarded.
  - Reset values: next_layer_valid = 0, next_layer_data = 0, next_layer_chan = 0, next_layer_last = 0 (NUM_CHANNEL > 1).
  - prev_layer_rdy = 0 while rst is high.
  - Accepting resumes on the first edge after rst falls.

## Timing
- Latency: a word accepted on edge N presents channel 0 in the cycle after edge N (valid high after edge N).
- Throughput: with next_layer_rdy held high, one beat per cycle.
  - A continuous input stream gives NUM_CHANNEL beats per word with zero idle cycles between words.
  - prev_layer_rdy pulses once every NUM_CHANNEL cycles.
- Drain: after the last beat transfers with no new input, next_layer_valid is low the following cycle.
- Simultaneous last-beat output and input transfer on the same edge: the next cycle shows the new word's channel 0.

## Test plan
- Single word, NUM_CHANNEL=3, BIT_WIDTH=8, input 0x332211, rdy held high.
  - Beats 0x11/0x22/0x33 on 3 consecutive cycles, chan 0/1/2, last only on 0x33.
  - Valid low on the 4th cycle.
- Back-to-back words 0x332211 then 0x665544, input valid and output rdy always high.
  - Six consecutive beats 11,22,33,44,55,66 with no gap.
  - prev_layer_rdy high only in IDLE and on the last-beat cycles.
- Backpressure: drop next_layer_rdy for 4 cycles while chan=1 (data 0x22).
  - data/chan/last hold for those 4 cycles.
  - prev_layer_rdy stays 0 throughout.
  - Sequence resumes with 0x33 and no beat is lost or duplicated.
- Reset mid-word: assert rst for 1 cycle after beat 0x11 transfers.
  - Next cycle: valid=0, chan=0, prev_layer_rdy=0 during rst.
  - A new word 0xCCBBAA afterwards yields AA,BB,CC with no 0x22/0x33 leftovers.
- NUM_CHANNEL=1 build: inputs 0x5A then 0xA5 back-to-back.
  - Outputs 0x5A then 0xA5 on consecutive cycles, last=1 and chan=0 on both.
- Random stream with random valid/rdy toggling, NUM_CHANNEL=5.
  - Scoreboard confirms in-order per-channel output and correct last on every 5th beat.
  - Output payload stays stable whenever valid && !rdy.

Source files
------------

// File: rtl/channel_serializer_if.sv
// Multi-channel layer interface: a word of NUM_CHANNEL lanes in, one channel beat out.
interface channel_serializer_if #(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned NUM_CHANNEL = 3
);
  localparam int unsigned CIDX_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;

  logic                             prev_layer_valid;
  logic                             prev_layer_rdy;
  logic [NUM_CHANNEL*BIT_WIDTH-1:0] prev_layer_data;
  logic                             next_layer_rdy;
  logic                             next_layer_valid;
  logic [BIT_WIDTH-1:0]             next_layer_data;
  logic [CIDX_W-1:0]                next_layer_chan;
  logic                             next_layer_last;

  // Producer of words / consumer of beats
  modport master (
    output prev_layer_valid, prev_layer_data, next_layer_rdy,
    input  prev_layer_rdy, next_layer_valid, next_layer_data, next_layer_chan, next_layer_last
  );

  // The serializer itself
  modport slave (
    input  prev_layer_valid, prev_layer_data, next_layer_rdy,
    output prev_layer_rdy, next_layer_valid, next_layer_data, next_layer_chan, next_layer_last
  );
endinterface

// File: rtl/channel_serializer.sv
// Splits one NUM_CHANNEL-lane word into ascending single-channel beats, one per cycle,
// with a zero-bubble reload when a new word arrives on the last beat.
module channel_serializer #(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned NUM_CHANNEL = 3
) (
  input logic                 clk,
  input logic                 rst,
  channel_serializer_if.slave bus
);
  localparam int unsigned CIDX_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam int unsigned WORD_W = NUM_CHANNEL * BIT_WIDTH;
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_CHANNEL - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [WORD_W-1:0]    hold_reg;
  logic [CIDX_W-1:0]    chan_cnt;
  logic                 valid_q;
  logic                 last_q;
  logic [BIT_WIDTH-1:0] data_q;

  logic [CIDX_W-1:0]    cnt_inc;
  logic [BIT_WIDTH-1:0] next_chan_data;
  logic                 rdy_c;
  logic                 in_xfer;
  logic                 out_xfer;

  // Channel that follows the one currently presented
  always_comb begin
    cnt_inc        = chan_cnt + CIDX_W'(1);
    next_chan_data = '0;
    for (int unsigned k = 0; k < NUM_CHANNEL; k++) begin
      if (CIDX_W'(k) == cnt_inc) next_chan_data = hold_reg[k*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Upstream may load on the very edge the last beat leaves
  assign rdy_c    = !rst && ((state == IDLE) || ((state == SEND) && last_q && bus.next_layer_rdy));
  assign in_xfer  = bus.prev_layer_valid && rdy_c;
  assign out_xfer = valid_q && bus.next_layer_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_reg <= '0;
      chan_cnt <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else if (in_xfer) begin
      state    <= SEND;
      hold_reg <= bus.prev_layer_data;
      chan_cnt <= '0;
      valid_q  <= 1'b1;
      last_q   <= (NUM_CHANNEL == 1);
      data_q   <= bus.prev_layer_data[BIT_WIDTH-1:0];
    end else if (out_xfer) begin
      if (!last_q) begin
        chan_cnt <= cnt_inc;
        data_q   <= next_chan_data;
        last_q   <= (cnt_inc == LAST_IDX);
      end else begin
        state   <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.prev_layer_rdy   = rdy_c;
  assign bus.next_layer_valid = valid_q;
  assign bus.next_layer_data  = data_q;
  assign bus.next_layer_chan  = chan_cnt;
  assign bus.next_layer_last  = last_q;
endmodule

// File: tb/tb_channel_serializer.sv
// Directed checks of channel_serializer for 3-, 1- and 5-channel builds.
module tb_channel_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  channel_serializer_if #(.BIT_WIDTH(8), .NUM_CHANNEL(3)) b3 ();
  channel_serializer_if #(.BIT_WIDTH(8), .NUM_CHANNEL(1)) b1 ();
  channel_serializer_if #(.BIT_WIDTH(8), .NUM_CHANNEL(5)) b5 ();

  channel_serializer #(.BIT_WIDTH(8), .NUM_CHANNEL(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  channel_serializer #(.BIT_WIDTH(8), .NUM_CHANNEL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  channel_serializer #(.BIT_WIDTH(8), .NUM_CHANNEL(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload is compared only when a beat is expected
  task automatic beat3(input string tag, input logic v, input logic [7:0] d,
                       input logic [1:0] c, input logic l, input logic r);
    check({tag, "_valid"}, 64'(b3.next_layer_valid), 64'(v));
    check({tag, "_prdy"},  64'(b3.prev_layer_rdy),   64'(r));
    if (v) begin
      check({tag, "_data"}, 64'(b3.next_layer_data), 64'(d));
      check({tag, "_chan"}, 64'(b3.next_layer_chan), 64'(c));
      check({tag, "_last"}, 64'(b3.next_layer_last), 64'(l));
    end
  endtask

  logic [39:0] word;
  logic [11:0] exp_q[$];
  logic [11:0] payload;
  logic [11:0] prev_payload;
  logic [11:0] ent;
  logic        pend;
  logic        prev_stall;

  initial begin
    b3.prev_layer_valid = 1'b0; b3.prev_layer_data = '0; b3.next_layer_rdy = 1'b0;
    b1.prev_layer_valid = 1'b0; b1.prev_layer_data = '0; b1.next_layer_rdy = 1'b0;
    b5.prev_layer_valid = 1'b0; b5.prev_layer_data = '0; b5.next_layer_rdy = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_valid", 64'(b3.next_layer_valid), 64'd0);
    check("rst_data",  64'(b3.next_layer_data),  64'd0);
    check("rst_chan",  64'(b3.next_layer_chan),  64'd0);
    check("rst_last",  64'(b3.next_layer_last),  64'd0);
    check("rst_prdy",  64'(b3.prev_layer_rdy),   64'd0);
    check("rst_valid5", 64'(b5.next_layer_valid), 64'd0);
    rst = 1'b0;

    // Single word
    b3.prev_layer_valid = 1'b1; b3.prev_layer_data = 24'h332211; b3.next_layer_rdy = 1'b1;
    #1 check("t1_idle_prdy", 64'(b3.prev_layer_rdy), 64'd1);
    tick(); b3.prev_layer_valid = 1'b0; #1 beat3("t1b0", 1, 8'h11, 0, 0, 0);
    tick(); beat3("t1b1", 1, 8'h22, 1, 0, 0);
    tick(); beat3("t1b2", 1, 8'h33, 2, 1, 1);
    tick(); beat3("t1end", 0, 8'h00, 0, 0, 1);

    // Back-to-back words
    b3.prev_layer_valid = 1'b1; b3.prev_layer_data = 24'h332211;
    #1 check("t2_idle_prdy", 64'(b3.prev_layer_rdy), 64'd1);
    tick(); b3.prev_layer_data = 24'h665544; #1 beat3("t2b0", 1, 8'h11, 0, 0, 0);
    tick(); beat3("t2b1", 1, 8'h22, 1, 0, 0);
    tick(); beat3("t2b2", 1, 8'h33, 2, 1, 1);
    tick(); b3.prev_layer_valid = 1'b0; #1 beat3("t2b3", 1, 8'h44, 0, 0, 0);
    tick(); beat3("t2b4", 1, 8'h55, 1, 0, 0);
    tick(); beat3("t2b5", 1, 8'h66, 2, 1, 1);
    tick(); beat3("t2end", 0, 8'h00, 0, 0, 1);

    // Backpressure on channel 1
    b3.prev_layer_valid = 1'b1; b3.prev_layer_data = 24'h332211;
    tick(); b3.prev_layer_valid = 1'b0; #1 beat3("t3b0", 1, 8'h11, 0, 0, 0);
    tick(); b3.next_layer_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 beat3($sformatf("t3hold%0d", i), 1, 8'h22, 1, 0, 0);
      if (i < 3) tick();
    end
    tick(); beat3("t3stall_end", 1, 8'h22, 1, 0, 0);
    b3.next_layer_rdy = 1'b1;
    tick(); beat3("t3b2", 1, 8'h33, 2, 1, 1);
    tick(); beat3("t3end", 0, 8'h00, 0, 0, 1);

    // Reset mid-word
    b3.prev_layer_valid = 1'b1; b3.prev_layer_data = 24'h332211;
    tick(); b3.prev_layer_valid = 1'b0; #1 beat3("t4b0", 1, 8'h11, 0, 0, 0);
    tick(); rst = 1'b1; #1 beat3("t4rst_cyc", 1, 8'h22, 1, 0, 0);
    tick();
    check("t4_valid", 64'(b3.next_layer_valid), 64'd0);
    check("t4_chan",  64'(b3.next_layer_chan),  64'd0);
    check("t4_data",  64'(b3.next_layer_data),  64'd0);
    check("t4_prdy_in_rst", 64'(b3.prev_layer_rdy), 64'd0);
    rst = 1'b0;
    b3.prev_layer_valid = 1'b1; b3.prev_layer_data = 24'hCCBBAA;
    #1 check("t4_prdy_after", 64'(b3.prev_layer_rdy), 64'd1);
    tick(); b3.prev_layer_valid = 1'b0; #1 beat3("t4n0", 1, 8'hAA, 0, 0, 0);
    tick(); beat3("t4n1", 1, 8'hBB, 1, 0, 0);
    tick(); beat3("t4n2", 1, 8'hCC, 2, 1, 1);
    tick(); beat3("t4end", 0, 8'h00, 0, 0, 1);

    // Single-channel build
    b1.prev_layer_valid = 1'b1; b1.prev_layer_data = 8'h5A; b1.next_layer_rdy = 1'b1;
    #1 check("t5_prdy0", 64'(b1.prev_layer_rdy), 64'd1);
    tick(); b1.prev_layer_data = 8'hA5; #1;
    check("t5_v0", 64'(b1.next_layer_valid), 64'd1);
    check("t5_d0", 64'(b1.next_layer_data),  64'h5A);
    check("t5_c0", 64'(b1.next_layer_chan),  64'd0);
    check("t5_l0", 64'(b1.next_layer_last),  64'd1);
    check("t5_prdy1", 64'(b1.prev_layer_rdy), 64'd1);
    tick(); b1.prev_layer_valid = 1'b0; #1;
    check("t5_v1", 64'(b1.next_layer_valid), 64'd1);
    check("t5_d1", 64'(b1.next_layer_data),  64'hA5);
    check("t5_c1", 64'(b1.next_layer_chan),  64'd0);
    check("t5_l1", 64'(b1.next_layer_last),  64'd1);
    tick();
    check("t5_end", 64'(b1.next_layer_valid), 64'd0);

    // Five-channel stream with random valid/ready
    pend = 1'b0; prev_stall = 1'b0; prev_payload = '0; word = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        word = 40'({$urandom(), $urandom()});
        pend = 1'b1;
      end
      b5.prev_layer_valid = pend;
      b5.prev_layer_data  = word;
      b5.next_layer_rdy   = ($urandom_range(0, 3) != 0);
      #1;
      payload = {b5.next_layer_last, 3'(b5.next_layer_chan), b5.next_layer_data};
      if (prev_stall) check("t6_stable", 64'(payload), 64'(prev_payload));
      if (b5.next_layer_valid && b5.next_layer_rdy) begin
        if (exp_q.size() == 0) check("t6_extra_beat", 64'(payload), 64'hFFFF);
        else begin
          ent = exp_q.pop_front();
          check("t6_beat", 64'(payload), 64'(ent));
        end
      end
      prev_stall   = b5.next_layer_valid && !b5.next_layer_rdy;
      prev_payload = payload;
      if (pend && b5.prev_layer_rdy) begin
        for (int k = 0; k < 5; k++) exp_q.push_back({(k == 4), 3'(k), word[k*8 +: 8]});
        pend = 1'b0;
      end
      tick();
    end
    b5.prev_layer_valid = 1'b0;
    b5.next_layer_rdy   = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      #1;
      payload = {b5.next_layer_last, 3'(b5.next_layer_chan), b5.next_layer_data};
      if (b5.next_layer_valid) begin
        ent = exp_q.pop_front();
        check("t6_drain", 64'(payload), 64'(ent));
      end
      tick();
    end
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    #1 check("t6_idle", 64'(b5.next_layer_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
